// File: rtl/matrix_pkg.sv
// Shared types and elaboration helpers for the LED matrix scanner.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        DISPLAY  = 2'd3
    } scan_state_t;

    function automatic int unsigned max_dim(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sck_timer.sv
// Down-counter timing one FSM state; done is high during the last cycle of the loaded period.
module sck_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt;
        if (load) begin
            cnt_d = load_val - W'(1);
        end else if (cnt != '0) begin
            cnt_d = cnt - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt  <= '0;
            done <= 1'b1;
        end else begin
            cnt  <= cnt_d;
            done <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scanning driver for two 74HC164 chains (columns, rows) with a double-buffered frame
// and brightness gating of the per-row on-time.
module led_matrix_scanner
    import matrix_pkg::*;
#(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 8,
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned BW      = 3,
    parameter int unsigned UNIT    = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic [ROWS*COLS-1:0] frame_data,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [BW-1:0]        bright,
    output logic                 scoldata,
    output logic                 srowdata,
    output logic                 sck,
    output logic                 oe_n,
    output logic                 frame_start
);

    localparam int unsigned N        = max_dim(ROWS, COLS);
    localparam int unsigned NW       = $clog2(N);
    localparam int unsigned RW       = $clog2(ROWS);
    localparam int unsigned DISP_LEN = ((1 << BW) - 1) * UNIT;
    localparam int unsigned TW       = $clog2(max_dim(DISP_LEN, CLK_DIV) + 1);

    scan_state_t state, next_state;

    logic [RW-1:0]        row, row_d;
    logic [NW-1:0]        bit_idx, bit_idx_d;
    logic [COLS-1:0]      front [ROWS];
    logic [ROWS*COLS-1:0] back;
    logic                 pending, pending_d;
    logic                 transfer, swap, row_start;
    logic [TW-1:0]        on_cnt, on_cnt_d, load_val;
    logic                 tmr_load, tmr_done;
    logic [N-1:0]         col_word;
    logic                 scoldata_d, srowdata_d, sck_d, oe_n_d, frame_start_d, frame_ready_d;

    sck_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .nrst     (nrst),
        .load     (tmr_load),
        .load_val (load_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (en) next_state = SHIFT_LO;
            SHIFT_LO: if (tmr_done) next_state = SHIFT_HI;
            SHIFT_HI: if (tmr_done) next_state = (bit_idx == '0) ? DISPLAY : SHIFT_LO;
            DISPLAY:  if (tmr_done) next_state = en ? SHIFT_LO : IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Next values of registered outputs and datapath, derived from the upcoming state.
    always_comb begin
        row_d         = row;
        bit_idx_d     = bit_idx;
        pending_d     = pending;
        on_cnt_d      = '0;
        scoldata_d    = scoldata;
        srowdata_d    = srowdata;
        sck_d         = 1'b0;
        oe_n_d        = 1'b1;
        frame_start_d = 1'b0;
        col_word      = '0;
        swap          = 1'b0;
        tmr_load      = 1'b0;
        load_val      = TW'(CLK_DIV);
        transfer      = frame_valid && frame_ready;
        row_start     = (next_state == SHIFT_LO) && ((state == IDLE) || (state == DISPLAY));

        if ((state == DISPLAY) && (next_state != DISPLAY)) begin
            if (row == RW'(ROWS - 1)) begin
                row_d = '0;
                swap  = pending;
            end else begin
                row_d = row + RW'(1);
            end
        end
        if ((state == IDLE) && (next_state == SHIFT_LO)) begin
            row_d = '0;
        end

        if (row_start) begin
            bit_idx_d = NW'(N - 1);
        end else if ((state == SHIFT_HI) && (next_state == SHIFT_LO)) begin
            bit_idx_d = bit_idx - NW'(1);
        end

        if (transfer) begin
            pending_d = 1'b1;
        end else if (swap) begin
            pending_d = 1'b0;
        end
        frame_ready_d = !pending_d;

        // A swapping row start must already present the new frame's row 0.
        if ((next_state == SHIFT_LO) && (state != SHIFT_LO)) begin
            col_word   = swap ? N'(back[COLS-1:0]) : N'(front[row_d]);
            scoldata_d = col_word[bit_idx_d];
            srowdata_d = (bit_idx_d == NW'(row_d));
        end
        frame_start_d = row_start && (row_d == '0);
        sck_d         = (next_state == SHIFT_HI);

        if (next_state == DISPLAY) begin
            if (state != DISPLAY) begin
                on_cnt_d = TW'(bright) * TW'(UNIT);
                oe_n_d   = (bright == '0);
            end else begin
                on_cnt_d = (on_cnt != '0) ? (on_cnt - TW'(1)) : '0;
                oe_n_d   = (on_cnt <= TW'(1));
            end
        end

        if ((next_state != state) && (next_state != IDLE)) begin
            tmr_load = 1'b1;
            load_val = (next_state == DISPLAY) ? TW'(DISP_LEN) : TW'(CLK_DIV);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            row         <= '0;
            bit_idx     <= '0;
            pending     <= 1'b0;
            on_cnt      <= '0;
            scoldata    <= 1'b0;
            srowdata    <= 1'b0;
            sck         <= 1'b0;
            oe_n        <= 1'b1;
            frame_start <= 1'b0;
            frame_ready <= 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                front[r] <= '0;
            end
        end else begin
            row         <= row_d;
            bit_idx     <= bit_idx_d;
            pending     <= pending_d;
            on_cnt      <= on_cnt_d;
            scoldata    <= scoldata_d;
            srowdata    <= srowdata_d;
            sck         <= sck_d;
            oe_n        <= oe_n_d;
            frame_start <= frame_start_d;
            frame_ready <= frame_ready_d;
            if (swap) begin
                for (int r = 0; r < ROWS; r++) begin
                    front[r] <= back[r*COLS +: COLS];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (transfer) begin
            back <= frame_data;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench: stimulus pushes expected per-row displays, a monitor rebuilds the chains.
module tb_led_matrix_scanner;

    localparam int R   = 4;
    localparam int C   = 6;
    localparam int CD  = 2;
    localparam int B   = 3;
    localparam int U   = 4;
    localparam int N   = (R > C) ? R : C;
    localparam int PIX = R * C;
    localparam int D   = ((1 << B) - 1) * U;
    localparam int P   = 2 * CD * N + D;
    localparam int FP  = R * P;
    localparam int NF  = 10;

    typedef struct {
        int           row;
        logic [N-1:0] col;
        logic [N-1:0] rw;
        int           on;
    } exp_t;

    logic           clk;
    logic           nrst;
    logic           en;
    logic [PIX-1:0] frame_data;
    logic           frame_valid;
    logic           frame_ready;
    logic [B-1:0]   bright;
    logic           scoldata;
    logic           srowdata;
    logic           sck;
    logic           oe_n;
    logic           frame_start;

    int             checks   = 0;
    int             failures = 0;
    int             cyc      = 0;
    int             rises    = 0;
    exp_t           q[$];
    logic [PIX-1:0] front_m;
    logic [PIX-1:0] pend_m;
    bit             pend_v;

    led_matrix_scanner #(
        .ROWS(R), .COLS(C), .CLK_DIV(CD), .BW(B), .UNIT(U)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .en          (en),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .bright      (bright),
        .scoldata    (scoldata),
        .srowdata    (srowdata),
        .sck         (sck),
        .oe_n        (oe_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected rows of the current front frame at the current brightness.
    function automatic void push_rows(input int nrows);
        exp_t           e;
        logic [PIX-1:0] sh;
        for (int r = 0; r < nrows; r++) begin
            sh           = front_m >> (r * C);
            e.row        = r;
            e.col        = '0;
            e.col[C-1:0] = sh[C-1:0];
            e.rw         = N'(1) << r;
            e.on         = int'(bright) * U;
            q.push_back(e);
        end
    endfunction

    task automatic wait_fs(output bit got);
        got = 1'b0;
        for (int k = 0; k < FP + 20; k++) begin
            @(negedge clk);
            if (frame_start) begin
                got = 1'b1;
                break;
            end
        end
        chk("fs_seen", 64'(got), 64'(1));
    endtask

    initial begin : stimulus
        bit got;
        int last_fs;
        int off;
        int d;
        int r0;
        nrst        = 1'b0;
        en          = 1'b0;
        frame_valid = 1'b0;
        frame_data  = '0;
        bright      = B'(7);
        front_m     = '0;
        pend_m      = '0;
        pend_v      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_oe_n", 64'(oe_n), 64'(1));
        chk("rst_sck", 64'(sck), 64'(0));
        chk("rst_ready", 64'(frame_ready), 64'(1));
        chk("rst_scol", 64'(scoldata), 64'(0));
        chk("rst_srow", 64'(srowdata), 64'(0));
        chk("rst_fs", 64'(frame_start), 64'(0));
        nrst = 1'b1;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("start_fs", 64'(frame_start), 64'(1));
        last_fs = cyc;
        push_rows(R);

        for (int f = 1; f <= NF; f++) begin
            if ($urandom_range(0, 3) != 0) begin
                off = int'($urandom_range(1, FP - P));
                repeat (off - 1) @(negedge clk);
                frame_data  = PIX'($urandom);
                frame_valid = 1'b1;
                pend_m      = frame_data;
                pend_v      = 1'b1;
                @(negedge clk);
                frame_valid = 1'b0;
                chk("ready_drop", 64'(frame_ready), 64'(0));
                if ($urandom_range(0, 1) != 0) begin
                    frame_data  = PIX'($urandom);
                    frame_valid = 1'b1;
                    @(negedge clk);
                    frame_valid = 1'b0;
                    chk("busy_ready", 64'(frame_ready), 64'(0));
                end
            end
            wait_fs(got);
            chk("fs_period", 64'(cyc - last_fs), 64'(FP));
            last_fs = cyc;
            chk("sb_drain", 64'(q.size()), 64'(0));
            chk("ready_at_fs", 64'(frame_ready), 64'(1));
            if (pend_v) front_m = pend_m;
            pend_v = 1'b0;
            case (f)
                1:       bright = B'(0);
                2:       bright = B'(7);
                3:       bright = B'(3);
                default: bright = B'($urandom_range(0, 7));
            endcase
            push_rows((f == NF) ? 1 : R);
        end

        // Drop en during row 0 shifting: only row 0 completes, then idle.
        d = int'($urandom_range(0, 2 * CD * N - 2));
        repeat (d) @(negedge clk);
        en = 1'b0;
        repeat (P + 10) @(negedge clk);
        chk("idle_oe_n", 64'(oe_n), 64'(1));
        chk("idle_sck", 64'(sck), 64'(0));
        chk("dis_drain", 64'(q.size()), 64'(0));
        r0 = rises;
        repeat (3 * P) @(negedge clk);
        chk("idle_quiet", 64'(rises - r0), 64'(0));

        en     = 1'b1;
        bright = B'($urandom_range(1, 7));
        @(negedge clk);
        chk("restart_fs", 64'(frame_start), 64'(1));
        last_fs = cyc;
        push_rows(R);
        wait_fs(got);
        chk("fs_period_restart", 64'(cyc - last_fs), 64'(FP));
        chk("final_drain", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : monitor
        logic [N-1:0] csr;
        logic [N-1:0] rsr;
        logic         psck;
        int           nr;
        int           bad_oe;
        int           low;
        int           perr;
        exp_t         e;
        csr  = '0;
        rsr  = '0;
        psck = 1'b0;
        wait (nrst === 1'b1);
        forever begin
            nr     = 0;
            bad_oe = 0;
            while (nr < N) begin
                @(negedge clk);
                if (!oe_n) bad_oe++;
                if (sck && !psck) begin
                    csr = {csr[N-2:0], scoldata};
                    rsr = {rsr[N-2:0], srowdata};
                    nr++;
                    rises++;
                end
                psck = sck;
            end
            do begin
                @(negedge clk);
                if (!oe_n && sck) bad_oe++;
            end while (sck);
            psck = sck;
            chk("row_expected", 64'(q.size() != 0), 64'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
            end else begin
                e.row = -1;
                e.col = '0;
                e.rw  = '0;
                e.on  = 0;
            end
            low  = 0;
            perr = 0;
            for (int j = 0; j < D; j++) begin
                if (j > 0) @(negedge clk);
                if (!oe_n) low++;
                if ((!oe_n) != (j < e.on)) perr++;
            end
            chk($sformatf("col_word_r%0d", e.row), 64'(csr), 64'(e.col));
            chk($sformatf("row_word_r%0d", e.row), 64'(rsr), 64'(e.rw));
            chk("oe_during_shift", 64'(bad_oe), 64'(0));
            chk($sformatf("oe_low_r%0d", e.row), 64'(low), 64'(e.on));
            chk("oe_window_order", 64'(perr), 64'(0));
        end
    end

endmodule
